dcache_line_refill_ctrl: RTL and testbench

//  Memory-side miss engine for the 2-way dcache/icache line arrays.

---
 rtl/dcache_line_refill_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_dcache_line_refill_ctrl.sv | 506 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_line_refill_ctrl.sv
// ============================================================================
// dcache_line_refill_ctrl
// ----------------------------------------------------------------------------
// Memory-side miss engine for the 2-way cache line arrays. It accepts one miss
// request, optionally writes back the dirty victim line, then reads the
// missing line one 32-bit beat at a time (8 beats per 256-bit line). The
// assembled line is presented with a one-cycle fill_valid pulse for the
// cache's write-fill cycle.
//
// Build option:
//   REFILL_WRITEBACK_EN  defined     : dirty victims are written back (WB state)
//                        not defined : victim_* inputs ignored, mem_we and
//                                      mem_wdata tied to 0 (write-through/icache)
//
// Ports:
//   clk, rst         clock (posedge), synchronous active-high reset
//   req_valid/ready  miss request handshake (accepted when both are 1)
//   miss_addr        any byte address inside the missing line
//   victim_dirty     replaced way holds dirty data
//   victim_addr      victim line base address
//   victim_line      victim line data
//   fill_valid       one-cycle pulse, fill_addr/fill_line valid
//   fill_addr        base address of refilled line
//   fill_line        refilled line, word k in bits [32k+31:32k]
//   busy             engine not idle
//   mem_req/we/addr/wdata  registered beat request to memory
//   mem_ack          beat complete (only counted while mem_req=1)
//   mem_rdata        read data, valid with mem_ack on read beats
//   dbg_state_o      current FSM state (debug/observability)
//
// Handshake rules:
//   req  : a request transfers on a posedge where req_valid & req_ready.
//          req_ready is 0 while busy and while rst is high.
//   mem  : a beat is presented (mem_req=1 plus addr/we/wdata) and held
//          stable until a posedge samples mem_ack=1; the next beat appears
//          the cycle after. mem_ack while mem_req=0 has no effect.
// ============================================================================
module dcache_line_refill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int MEM_DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    input  logic [LINE_W-1:0] victim_line,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [LINE_W-1:0] fill_line,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [MEM_DW-1:0] mem_rdata,
    output logic [1:0]        dbg_state_o
);

    localparam int BEATS  = LINE_W / MEM_DW;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int WOFF_W = $clog2(MEM_DW / 8);
    localparam int BASE_W = ADDR_W - OFF_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_RD   = 2'd2,
        S_FILL = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic                fill_valid_q, fill_valid_d;
    logic [LINE_W-1:0]   fill_line_q, fill_line_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
`ifdef REFILL_WRITEBACK_EN
    logic [BASE_W-1:0]   vbase_q, vbase_d;
    logic [LINE_W-1:0]   vline_q, vline_d;
    logic                mem_we_q, mem_we_d;
    logic [MEM_DW-1:0]   mem_wdata_q, mem_wdata_d;
`endif

    logic                accept;
    logic                beat_done;
    logic                last_beat;
    logic                wb_start;
    logic [CNT_W-1:0]    cnt_inc;
    logic [BASE_W-1:0]   miss_base;
    logic [BASE_W-1:0]   victim_base;

    assign req_ready   = (state_q == S_IDLE) & ~rst;
    assign accept      = req_valid & req_ready;
    // An ack only completes a beat while a beat is actually presented.
    assign beat_done   = mem_req_q & mem_ack;
    assign last_beat   = (cnt_q == LAST_BEAT);
    // Counter wraps to 0 after the last beat, so each phase starts at word 0.
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign miss_base   = miss_addr[ADDR_W-1:OFF_W];
    assign victim_base = victim_addr[ADDR_W-1:OFF_W];

`ifdef REFILL_WRITEBACK_EN
    assign wb_start = victim_dirty;
    logic unused_bits;
    assign unused_bits = ^{miss_addr[OFF_W-1:0], victim_addr[OFF_W-1:0]};
`else
    assign wb_start = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{miss_addr[OFF_W-1:0], victim_addr, victim_dirty, victim_line};
`endif

    // ------------------------------------------------------------------
    // State register (and all datapath registers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            base_q       <= '0;
            fill_valid_q <= 1'b0;
            fill_line_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
`ifdef REFILL_WRITEBACK_EN
            vbase_q      <= '0;
            vline_q      <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            fill_valid_q <= fill_valid_d;
            fill_line_q  <= fill_line_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
`ifdef REFILL_WRITEBACK_EN
            vbase_q      <= vbase_d;
            vline_q      <= vline_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = wb_start ? S_WB : S_RD;
            S_WB:   if (beat_done && last_beat) state_d = S_RD;
            S_RD:   if (beat_done && last_beat) state_d = S_FILL;
            S_FILL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values. Beat outputs are registered so the
    // first beat appears the cycle after entering WB or RD.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d        = cnt_q;
        base_d       = base_q;
        fill_valid_d = 1'b0;
        fill_line_d  = fill_line_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
`ifdef REFILL_WRITEBACK_EN
        vbase_d      = vbase_q;
        vline_d      = vline_q;
        mem_we_d     = mem_we_q;
        mem_wdata_d  = mem_wdata_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    base_d     = miss_base;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {miss_base, {OFF_W{1'b0}}};
`ifdef REFILL_WRITEBACK_EN
                    vbase_d     = victim_base;
                    vline_d     = victim_line;
                    mem_we_d    = victim_dirty;
                    mem_wdata_d = '0;
                    if (victim_dirty) begin
                        mem_addr_d  = {victim_base, {OFF_W{1'b0}}};
                        mem_wdata_d = victim_line[MEM_DW-1:0];
                    end
`endif
                end
            end
`ifdef REFILL_WRITEBACK_EN
            S_WB: begin
                if (beat_done) begin
                    cnt_d = cnt_inc;
                    if (last_beat) begin
                        // Roll straight into the first read beat: no idle gap.
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                        mem_addr_d  = {base_q, {OFF_W{1'b0}}};
                    end else begin
                        mem_addr_d  = {vbase_q, cnt_inc, {WOFF_W{1'b0}}};
                        mem_wdata_d = vline_q[int'(cnt_inc)*MEM_DW +: MEM_DW];
                    end
                end
            end
`endif
            S_RD: begin
                if (beat_done) begin
                    cnt_d = cnt_inc;
                    fill_line_d[int'(cnt_q)*MEM_DW +: MEM_DW] = mem_rdata;
                    if (last_beat) begin
                        mem_req_d    = 1'b0;
                        fill_valid_d = 1'b1;
                    end else begin
                        mem_addr_d = {base_q, cnt_inc, {WOFF_W{1'b0}}};
                    end
                end
            end
            default: ;
        endcase
    end

    assign fill_valid  = fill_valid_q;
    assign fill_addr   = {base_q, {OFF_W{1'b0}}};
    assign fill_line   = fill_line_q;
    assign busy        = (state_q != S_IDLE);
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign dbg_state_o = state_q;
`ifdef REFILL_WRITEBACK_EN
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
`else
    assign mem_we    = 1'b0;
    assign mem_wdata = '0;
`endif

endmodule

// File: tb/tb_dcache_line_refill_ctrl.sv
// Testbench for dcache_line_refill_ctrl: a bench-side memory responder with
// configurable wait states, a bus monitor, and a transaction-level model that
// predicts the beat list, the filled line and the fill latency of each miss.
module tb_dcache_line_refill_ctrl;

`ifdef REFILL_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  always #5 clk = ~clk;

  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  miss_addr = '0;
  logic         victim_dirty = 1'b0;
  logic [31:0]  victim_addr = '0;
  logic [255:0] victim_line = '0;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic [255:0] fill_line;
  logic         busy;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ack = 1'b0;
  logic [31:0]  mem_rdata;
  logic [1:0]   dbg_state;

  dcache_line_refill_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .miss_addr    (miss_addr),
    .victim_dirty (victim_dirty),
    .victim_addr  (victim_addr),
    .victim_line  (victim_line),
    .fill_valid   (fill_valid),
    .fill_addr    (fill_addr),
    .fill_line    (fill_line),
    .busy         (busy),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .dbg_state_o  (dbg_state)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- bench memory ----------------
  bit          rd_mode_k = 1'b0;   // 1: word k of a line reads 0x1000_0000+k
  logic [31:0] rd_key = 32'h5a5a_0000;
  int          wait_cfg = 0;       // wait cycles before each ack
  bit          spur_en = 1'b0;     // random acks while mem_req=0
  int          wait_ctr = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (rd_mode_k) return 32'h1000_0000 + {29'd0, a[4:2]};
    return a ^ rd_key;
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  always @(negedge clk) begin
    if (rst || !mem_req) begin
      wait_ctr = 0;
      mem_ack  = (spur_en && !rst) ? 1'($urandom_range(0, 1)) : 1'b0;
    end else if (wait_ctr >= wait_cfg) begin
      mem_ack  = 1'b1;
      wait_ctr = 0;
    end else begin
      mem_ack  = 1'b0;
      wait_ctr++;
    end
  end

  // ---------------- monitor ----------------
  int           cyc = 0;
  logic [64:0]  obs_q[$];          // {we, addr, wdata}
  int           acc_cyc[$];
  int           fill_cyc[$];
  logic [31:0]  fill_addr_q[$];
  logic [255:0] fill_line_q[$];
  int           stab_err = 0;
  int           we_beats = 0;
  bit           pend_v = 1'b0;
  logic [64:0]  pend_beat = '0;

  always @(posedge clk) begin
    if (rst) begin
      pend_v = 1'b0;
    end else begin
      if (pend_v && (!mem_req || {mem_we, mem_addr, mem_wdata} !== pend_beat)) stab_err++;
      if (mem_req && mem_ack) begin
        obs_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 32'h0});
        if (mem_we) we_beats++;
      end
      pend_v    = mem_req && !mem_ack;
      pend_beat = {mem_we, mem_addr, mem_wdata};
      if (req_valid && req_ready) acc_cyc.push_back(cyc);
      if (fill_valid) begin
        fill_cyc.push_back(cyc);
        fill_addr_q.push_back(fill_addr);
        fill_line_q.push_back(fill_line);
      end
    end
    cyc++;
  end

  // ---------------- scoreboard / reference model ----------------
  logic [64:0]  exp_q[$];
  logic [31:0]  exp_fill_addr_q[$];
  logic [255:0] exp_fill_line_q[$];
  int           exp_lat = 0;

  task automatic clear_mon();
    obs_q.delete(); acc_cyc.delete(); fill_cyc.delete();
    fill_addr_q.delete(); fill_line_q.delete();
    exp_q.delete(); exp_fill_addr_q.delete(); exp_fill_line_q.delete();
    stab_err = 0; we_beats = 0;
  endtask

  // Transaction-level prediction: optional 8-word writeback of the victim
  // line, then 8 reads of the missing line; every beat costs (w+1) cycles and
  // the fill pulse follows the final ack by one cycle.
  task automatic model_miss(input logic [31:0] maddr, input bit vd,
                            input logic [31:0] vaddr, input logic [255:0] vline,
                            input int w);
    logic [31:0]  mb, vb;
    logic [255:0] line;
    int           n;
    mb = maddr & 32'hFFFF_FFE0;
    vb = vaddr & 32'hFFFF_FFE0;
    n  = 0;
    line = '0;
    if (WB_EN && vd) begin
      for (int k = 0; k < 8; k++) begin
        exp_q.push_back({1'b1, vb + 32'(4 * k), vline[k*32 +: 32]});
        n++;
      end
    end
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({1'b0, mb + 32'(4 * k), 32'h0});
      line[k*32 +: 32] = mem_word(mb + 32'(4 * k));
      n++;
    end
    exp_fill_addr_q.push_back(mb);
    exp_fill_line_q.push_back(line);
    exp_lat = 1 + n * (w + 1);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // ---------------- driver ----------------
  task automatic run_miss(input logic [31:0] maddr, input bit vd,
                          input logic [31:0] vaddr, input logic [255:0] vline,
                          input int w);
    clear_mon();
    wait_cfg = w;
    model_miss(maddr, vd, vaddr, vline, w);
    @(negedge clk);
    req_valid = 1'b1; miss_addr = maddr; victim_dirty = vd;
    victim_addr = vaddr; victim_line = vline;
    for (int i = 0; i < 20 && acc_cyc.size() == 0; i++) @(negedge clk);
    // Scramble inputs after acceptance: the engine must have latched them.
    req_valid = 1'b0; miss_addr = $urandom; victim_dirty = 1'($urandom_range(0, 1));
    victim_addr = $urandom; victim_line = rand_line();
    for (int i = 0; i < 400 && fill_cyc.size() == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({req_ready, busy, mem_req, mem_we, fill_valid} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got ready/busy/req/we/fv=%b exp 00000",
               {req_ready, busy, mem_req, mem_we, fill_valid});
    end
    tests_run++;
    if ({mem_addr, mem_wdata, fill_addr} !== 96'h0 || fill_line !== 256'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got addr=%h wdata=%h faddr=%h fline=%h exp all zero",
               mem_addr, mem_wdata, fill_addr, fill_line);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b exp 1", req_ready);
    end
  endtask

  task automatic test_clean_miss();
    rd_mode_k = 1'b1;
    run_miss(32'h0000_1234, 1'b0, 32'h0, '0, 0);
    tests_run++;
    if (fill_cyc.size() != 1 || acc_cyc.size() != 1) begin
      tests_failed++;
      $display("FAIL clean_fill_count: got fills=%0d accepts=%0d exp 1/1", fill_cyc.size(), acc_cyc.size());
    end else begin
      tests_run++;
      if (fill_cyc[0] - acc_cyc[0] != 9) begin
        tests_failed++;
        $display("FAIL clean_latency: got T+%0d exp T+9", fill_cyc[0] - acc_cyc[0]);
      end
      tests_run++;
      if (fill_addr_q[0] !== 32'h0000_1220) begin
        tests_failed++;
        $display("FAIL clean_fill_addr: got %h exp 00001220", fill_addr_q[0]);
      end
      for (int k = 0; k < 8; k++) begin
        tests_run++;
        if (fill_line_q[0][k*32 +: 32] !== 32'h1000_0000 + 32'(k)) begin
          tests_failed++;
          $display("FAIL clean_fill_word%0d: got %h exp %h", k, fill_line_q[0][k*32 +: 32], 32'h1000_0000 + 32'(k));
        end
      end
    end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL clean_beat_count: got %0d exp %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL clean_beat%0d: got %h exp %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    rd_mode_k = 1'b0;
  endtask

  task automatic test_dirty_miss();
    logic [255:0] vl;
    for (int k = 0; k < 8; k++) vl[k*32 +: 32] = 32'hA0 + 32'(k);
    rd_key = $urandom;
    run_miss(32'h0000_3000 | 32'($urandom_range(0, 31)), 1'b1, 32'h0000_8040, vl, 0);
    tests_run++;
    if (fill_cyc.size() != 1 || acc_cyc.size() != 1) begin
      tests_failed++;
      $display("FAIL dirty_fill_count: got fills=%0d accepts=%0d exp 1/1", fill_cyc.size(), acc_cyc.size());
    end else begin
      tests_run++;
      if (fill_cyc[0] - acc_cyc[0] != (WB_EN ? 17 : 9)) begin
        tests_failed++;
        $display("FAIL dirty_latency: got T+%0d exp T+%0d", fill_cyc[0] - acc_cyc[0], WB_EN ? 17 : 9);
      end
      tests_run++;
      if (fill_line_q[0] !== exp_fill_line_q[0]) begin
        tests_failed++;
        $display("FAIL dirty_fill_line: got %h exp %h", fill_line_q[0], exp_fill_line_q[0]);
      end
    end
    tests_run++;
    if (we_beats != (WB_EN ? 8 : 0)) begin
      tests_failed++;
      $display("FAIL dirty_write_beats: got %0d exp %0d", we_beats, WB_EN ? 8 : 0);
    end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL dirty_beat_count: got %0d exp %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL dirty_beat%0d: got %h exp %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    rd_key = $urandom;
    run_miss(32'h0000_5a7c, 1'b0, 32'h0, '0, 2);
    tests_run++;
    if (fill_cyc.size() != 1 || acc_cyc.size() != 1) begin
      tests_failed++;
      $display("FAIL wait_fill_count: got fills=%0d accepts=%0d exp 1/1", fill_cyc.size(), acc_cyc.size());
    end else begin
      tests_run++;
      if (fill_cyc[0] - acc_cyc[0] != 25) begin
        tests_failed++;
        $display("FAIL wait_latency: got T+%0d exp T+25", fill_cyc[0] - acc_cyc[0]);
      end
      tests_run++;
      if (fill_line_q[0] !== exp_fill_line_q[0]) begin
        tests_failed++;
        $display("FAIL wait_fill_line: got %h exp %h", fill_line_q[0], exp_fill_line_q[0]);
      end
    end
    tests_run++;
    if (stab_err != 0) begin
      tests_failed++;
      $display("FAIL wait_stability: got %0d unstable cycles exp 0", stab_err);
    end
    tests_run++;
    if (obs_q.size() != 8) begin
      tests_failed++;
      $display("FAIL wait_beat_count: got %0d exp 8", obs_q.size());
    end
    wait_cfg = 0;
  endtask

  task automatic test_mid_reset();
    clear_mon();
    wait_cfg = 0;
    @(negedge clk);
    req_valid = 1'b1; miss_addr = $urandom; victim_dirty = 1'b0;
    for (int i = 0; i < 20 && acc_cyc.size() == 0; i++) @(negedge clk);
    req_valid = 1'b0;
    // Wait until read beat 4 is on the bus (four acks done).
    for (int i = 0; i < 40 && obs_q.size() < 4; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({mem_req, busy, fill_valid, req_ready} !== 4'b0) begin
      tests_failed++;
      $display("FAIL midrst_ctrl: got req/busy/fv/ready=%b exp 0000", {mem_req, busy, fill_valid, req_ready});
    end
    tests_run++;
    if (fill_line !== 256'h0) begin
      tests_failed++;
      $display("FAIL midrst_fill_line: got %h exp 0", fill_line);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_ready: got %b exp 1", req_ready);
    end
    repeat (12) @(negedge clk);
    tests_run++;
    if (fill_cyc.size() != 0 || obs_q.size() != 4) begin
      tests_failed++;
      $display("FAIL midrst_no_fill: got fills=%0d beats=%0d exp 0/4", fill_cyc.size(), obs_q.size());
    end
    rd_key = $urandom;
    run_miss(32'h0000_0040, 1'b0, 32'h0, '0, 0);
    tests_run++;
    if (fill_cyc.size() != 1) begin
      tests_failed++;
      $display("FAIL midrst_next_count: got %0d exp 1", fill_cyc.size());
    end else begin
      tests_run++;
      if (fill_addr_q[0] !== 32'h40 || fill_line_q[0] !== exp_fill_line_q[0]) begin
        tests_failed++;
        $display("FAIL midrst_next_data: got %h/%h exp 00000040/%h", fill_addr_q[0], fill_line_q[0], exp_fill_line_q[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    clear_mon();
    wait_cfg = 0;
    rd_key = $urandom;
    a = $urandom; b = $urandom;
    spur_en = 1'b1;
    repeat (6) @(negedge clk);
    tests_run++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_spurious_idle: got beats=%0d busy=%b exp 0/0", obs_q.size(), busy);
    end
    model_miss(a, 1'b0, 32'h0, '0, 0);
    model_miss(b, 1'b0, 32'h0, '0, 0);
    req_valid = 1'b1; miss_addr = a; victim_dirty = 1'b0;
    for (int i = 0; i < 20 && acc_cyc.size() == 0; i++) @(negedge clk);
    miss_addr = b;  // request stays asserted while the engine is busy
    for (int i = 0; i < 100 && acc_cyc.size() < 2; i++) @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 100 && fill_cyc.size() < 2; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    spur_en = 1'b0;
    tests_run++;
    if (acc_cyc.size() != 2 || fill_cyc.size() != 2) begin
      tests_failed++;
      $display("FAIL b2b_counts: got accepts=%0d fills=%0d exp 2/2", acc_cyc.size(), fill_cyc.size());
    end else begin
      tests_run++;
      if (acc_cyc[1] != fill_cyc[0] + 1) begin
        tests_failed++;
        $display("FAIL b2b_second_accept: got cycle %0d exp %0d", acc_cyc[1], fill_cyc[0] + 1);
      end
      for (int j = 0; j < 2; j++) begin
        tests_run++;
        if (fill_addr_q[j] !== exp_fill_addr_q[j] || fill_line_q[j] !== exp_fill_line_q[j]) begin
          tests_failed++;
          $display("FAIL b2b_fill%0d: got %h/%h exp %h/%h", j, fill_addr_q[j], fill_line_q[j], exp_fill_addr_q[j], exp_fill_line_q[j]);
        end
      end
    end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL b2b_beat_count: got %0d exp %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL b2b_beat%0d: got %h exp %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0]  ma, va;
    logic [255:0] vl;
    bit           vd;
    int           w;
    for (int it = 0; it < 8; it++) begin
      rd_key = $urandom;
      ma = $urandom;
      vd = 1'($urandom_range(0, 1));
      va = $urandom;
      vl = rand_line();
      w  = $urandom_range(0, 2);
      if (it == 0) begin
        vd = 1'b1;                       // victim is the missing line itself
        va = ma & 32'hFFFF_FFE0;
      end
      run_miss(ma, vd, va, vl, w);
      tests_run++;
      if (fill_cyc.size() != 1 || acc_cyc.size() != 1) begin
        tests_failed++;
        $display("FAIL rand%0d_fill_count: got fills=%0d accepts=%0d exp 1/1", it, fill_cyc.size(), acc_cyc.size());
      end else begin
        tests_run++;
        if (fill_cyc[0] - acc_cyc[0] != exp_lat) begin
          tests_failed++;
          $display("FAIL rand%0d_latency: got %0d exp %0d", it, fill_cyc[0] - acc_cyc[0], exp_lat);
        end
        tests_run++;
        if (fill_addr_q[0] !== exp_fill_addr_q[0] || fill_line_q[0] !== exp_fill_line_q[0]) begin
          tests_failed++;
          $display("FAIL rand%0d_fill: got %h/%h exp %h/%h", it, fill_addr_q[0], fill_line_q[0], exp_fill_addr_q[0], exp_fill_line_q[0]);
        end
      end
      tests_run++;
      if (stab_err != 0) begin
        tests_failed++;
        $display("FAIL rand%0d_stability: got %0d exp 0", it, stab_err);
      end
      tests_run++;
      if (obs_q.size() != exp_q.size()) begin
        tests_failed++;
        $display("FAIL rand%0d_beat_count: got %0d exp %0d", it, obs_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          tests_run++;
          if (obs_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL rand%0d_beat%0d: got %h exp %h", it, i, obs_q[i], exp_q[i]);
          end
        end
      end
    end
    wait_cfg = 0;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_wait_states();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

endmodule
